// File: rtl/mmio_timer.sv
`default_nettype none
// ============================================================================
//  Module   : mmio_timer
//  Purpose  : Memory-mapped countdown timer with a prescaler, optional
//             auto-reload and a sticky expiry flag. Decodes a 4-word
//             register window on the CPU memory bus.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk         in   1   system clock, all state updates on posedge
//    reset       in   1   synchronous, active-high reset
//    mem_cmd     in   3   one-hot bus command (001 none, 010 read, 100 write)
//    mem_addr    in   9   CPU word address
//    write_data  in  16   CPU store data
//    read_data   out 16   register read value, zero when rd_en is low
//    rd_en       out  1   read hit in the register window
//    done        out  1   sticky expiry flag
//    count       out 16   current counter value
//  Register map (offset = mem_addr[1:0])
//    0 CTRL   : bit0 en (reads 1 only while running), bit1 auto_reload
//    1 LOAD   : reload value
//    2 COUNT  : current count
//    3 STATUS : bit0 done (write 1 to clear), bit1 running
// ============================================================================
module mmio_timer #(
  parameter logic [8:0] BASE_ADDR = 9'h180,
  parameter int         PRESCALE  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  mem_cmd,
  input  logic [8:0]  mem_addr,
  input  logic [15:0] write_data,
  output logic [15:0] read_data,
  output logic        rd_en,
  output logic        done,
  output logic [15:0] count
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [2:0] CMD_READ  = 3'b010;
  localparam logic [2:0] CMD_WRITE = 3'b100;

  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_LOAD   = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;
  localparam logic [1:0] OFF_STATUS = 2'd3;

  // Prescaler needs at least one bit even when PRESCALE is 1.
  localparam int              PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  // --------------------------------------------------------------------------
  // State machine encoding
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_t;

  state_t            state, state_next;
  logic              auto_reload, auto_reload_next;
  logic [15:0]       load_val, load_val_next;
  logic [15:0]       count_q, count_next;
  logic [PRE_W-1:0]  prescaler, prescaler_next;
  logic              done_q, done_next;

  // --------------------------------------------------------------------------
  // Bus decode
  // --------------------------------------------------------------------------
  logic       sel;
  logic       wr;
  logic       rd;
  logic [1:0] offset;

  assign sel    = (mem_addr[8:2] == BASE_ADDR[8:2]);
  assign wr     = sel && (mem_cmd == CMD_WRITE);
  assign rd     = sel && (mem_cmd == CMD_READ);
  assign offset = mem_addr[1:0];

  // --------------------------------------------------------------------------
  // Status helpers
  // --------------------------------------------------------------------------
  logic running;
  logic tick;

  assign running = (state == RUN);
  assign tick    = running && (prescaler == PRE_LAST);

  // --------------------------------------------------------------------------
  // Combinational read path; reads have no side effects.
  // --------------------------------------------------------------------------
  always_comb begin
    read_data = 16'h0000;
    if (rd) begin
      unique case (offset)
        OFF_CTRL:   read_data = {14'd0, auto_reload, running};
        OFF_LOAD:   read_data = load_val;
        OFF_COUNT:  read_data = count_q;
        OFF_STATUS: read_data = {14'd0, running, done_q};
        default:    read_data = 16'h0000;
      endcase
    end
  end

  assign rd_en = rd;
  assign done  = done_q;
  assign count = count_q;

  // --------------------------------------------------------------------------
  // Next-state logic: the counter engine is evaluated first, then bus writes
  // override the parts they own. done is resolved last so that a same-cycle
  // expiry always beats a software clear.
  // --------------------------------------------------------------------------
  logic set_done;
  logic clr_done;

  always_comb begin
    state_next       = state;
    auto_reload_next = auto_reload;
    load_val_next    = load_val;
    count_next       = count_q;
    prescaler_next   = prescaler;
    set_done         = 1'b0;
    clr_done         = 1'b0;

    // Counter engine
    if (running) begin
      if (tick) begin
        prescaler_next = '0;
      end else begin
        prescaler_next = prescaler + 1'b1;
      end
    end

    if (tick) begin
      if (count_q > 16'd1) begin
        count_next = count_q - 16'd1;
      end else begin
        // Reaching 1 (or starting from 0) expires; the counter never wraps.
        set_done = 1'b1;
        if (auto_reload && (load_val != 16'd0)) begin
          count_next = load_val;
        end else begin
          count_next = 16'd0;
          state_next = EXPIRED;
        end
      end
    end

    // Bus writes
    if (wr) begin
      unique case (offset)
        OFF_CTRL: begin
          auto_reload_next = write_data[1];
          if (write_data[0]) begin
            // Starting only happens from a stopped state; a set while
            // running merely changes the reload mode and lets any
            // same-cycle tick proceed.
            if (!running) begin
              count_next     = load_val;
              prescaler_next = '0;
              state_next     = RUN;
            end
          end else begin
            // Stop wins over a same-cycle tick: count holds.
            state_next     = IDLE;
            count_next     = count_q;
            prescaler_next = '0;
            set_done       = 1'b0;
          end
        end
        OFF_LOAD: begin
          load_val_next = write_data;
        end
        OFF_COUNT: begin
          // A direct count write suppresses the whole tick, including any
          // expiry it would have caused.
          count_next     = write_data;
          prescaler_next = '0;
          state_next     = state;
          set_done       = 1'b0;
        end
        OFF_STATUS: begin
          clr_done = write_data[0];
        end
        default: begin
        end
      endcase
    end

    if (set_done) begin
      done_next = 1'b1;
    end else if (clr_done) begin
      done_next = 1'b0;
    end else begin
      done_next = done_q;
    end
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      auto_reload <= 1'b0;
      load_val    <= 16'd0;
      count_q     <= 16'd0;
      prescaler   <= '0;
      done_q      <= 1'b0;
    end else begin
      state       <= state_next;
      auto_reload <= auto_reload_next;
      load_val    <= load_val_next;
      count_q     <= count_next;
      prescaler   <= prescaler_next;
      done_q      <= done_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mmio_timer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mmio_timer
//  Purpose  : Directed self-checking bench for mmio_timer (PRESCALE = 4).
//  Revision : 1.0  initial release
// ============================================================================
module tb_mmio_timer;

  localparam logic [2:0] CMD_NONE  = 3'b001;
  localparam logic [2:0] CMD_READ  = 3'b010;
  localparam logic [2:0] CMD_WRITE = 3'b100;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  mem_cmd;
  logic [8:0]  mem_addr;
  logic [15:0] write_data;
  logic [15:0] read_data;
  logic        rd_en;
  logic        done;
  logic [15:0] count;

  int checks = 0;
  int errors = 0;

  mmio_timer #(
    .BASE_ADDR (9'h180),
    .PRESCALE  (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_cmd    (mem_cmd),
    .mem_addr   (mem_addr),
    .write_data (write_data),
    .read_data  (read_data),
    .rd_en      (rd_en),
    .done       (done),
    .count      (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Each bus write consumes exactly one rising edge; returns 1ns after it.
  task automatic bus_write(input logic [8:0] a, input logic [15:0] d);
    mem_cmd    = CMD_WRITE;
    mem_addr   = a;
    write_data = d;
    @(posedge clk);
    #1;
    mem_cmd    = CMD_NONE;
    mem_addr   = 9'h000;
    write_data = 16'h0000;
  endtask

  task automatic bus_read(input logic [8:0] a, output logic [15:0] d, output logic e);
    mem_cmd  = CMD_READ;
    mem_addr = a;
    #1;
    d = read_data;
    e = rd_en;
    mem_cmd  = CMD_NONE;
    mem_addr = 9'h000;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic read_check(input string tag, input logic [8:0] a,
                            input logic [15:0] exp_d, input logic exp_e);
    logic [15:0] d;
    logic        e;
    bus_read(a, d, e);
    check({tag, "_data"}, d, exp_d);
    check({tag, "_rden"}, {15'd0, e}, {15'd0, exp_e});
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset      = 1'b1;
    mem_cmd    = CMD_NONE;
    mem_addr   = 9'h000;
    write_data = 16'h0000;
    step(2);
    reset = 1'b0;

    // Reset state
    check("rst_count", count, 16'h0000);
    check("rst_done", {15'd0, done}, 16'h0000);
    read_check("rst_ctrl",   9'h180, 16'h0000, 1'b1);
    read_check("rst_load",   9'h181, 16'h0000, 1'b1);
    read_check("rst_count",  9'h182, 16'h0000, 1'b1);
    read_check("rst_status", 9'h183, 16'h0000, 1'b1);
    read_check("rd_led",     9'h100, 16'h0000, 1'b0);

    // One-shot countdown, LOAD=3
    bus_write(9'h181, 16'd3);
    bus_write(9'h180, 16'h0001);               // edge N
    check("os_n0", count, 16'd3);
    step(4);                                   // N+4
    check("os_n4", count, 16'd2);
    read_check("os_status_run", 9'h183, 16'h0002, 1'b1);
    step(4);                                   // N+8
    check("os_n8", count, 16'd1);
    step(3);                                   // N+11
    check("os_n11_done", {15'd0, done}, 16'h0000);
    check("os_n11_count", count, 16'd1);
    step(1);                                   // N+12
    check("os_n12_count", count, 16'd0);
    check("os_n12_done", {15'd0, done}, 16'h0001);
    read_check("os_status_exp", 9'h183, 16'h0001, 1'b1);
    read_check("os_ctrl_exp",   9'h180, 16'h0000, 1'b1);
    step(4);
    check("os_sat", count, 16'd0);

    // Auto-reload, LOAD=2
    bus_write(9'h183, 16'h0001);
    check("ar_clr", {15'd0, done}, 16'h0000);
    bus_write(9'h181, 16'd2);
    bus_write(9'h180, 16'h0003);               // edge N
    check("ar_n0", count, 16'd2);
    step(7);                                   // N+7
    check("ar_n7_done", {15'd0, done}, 16'h0000);
    check("ar_n7_count", count, 16'd1);
    step(1);                                   // N+8
    check("ar_n8_done", {15'd0, done}, 16'h0001);
    check("ar_n8_count", count, 16'd2);
    read_check("ar_status", 9'h183, 16'h0003, 1'b1);
    bus_write(9'h183, 16'h0001);               // N+9
    check("ar_n9_clr", {15'd0, done}, 16'h0000);
    step(6);                                   // N+15
    check("ar_n15_done", {15'd0, done}, 16'h0000);
    check("ar_n15_count", count, 16'd1);
    step(1);                                   // N+16
    check("ar_n16_done", {15'd0, done}, 16'h0001);

    // Clear/set collision at N+24
    bus_write(9'h183, 16'h0001);               // N+17
    check("col_pre_clr", {15'd0, done}, 16'h0000);
    step(6);                                   // N+23
    check("col_n23", {15'd0, done}, 16'h0000);
    bus_write(9'h183, 16'h0001);               // N+24, expiry edge
    check("col_n24_done", {15'd0, done}, 16'h0001);
    check("col_n24_count", count, 16'd2);

    // COUNT write on a tick edge (N+28)
    step(3);                                   // N+27
    check("cw_n27", count, 16'd2);
    bus_write(9'h182, 16'h0010);               // N+28
    check("cw_n28", count, 16'h0010);
    step(3);                                   // N+31
    check("cw_n31", count, 16'h0010);
    step(1);                                   // N+32
    check("cw_n32", count, 16'h000F);

    // Stop
    bus_write(9'h180, 16'h0000);
    check("stop_count", count, 16'h000F);
    step(8);
    check("stop_frozen", count, 16'h000F);
    read_check("stop_status", 9'h183, 16'h0001, 1'b1);
    read_check("stop_ctrl",   9'h180, 16'h0000, 1'b1);

    // Reset mid-run with count=5
    bus_write(9'h181, 16'd5);
    bus_write(9'h180, 16'h0001);
    step(2);
    check("mr_count5", count, 16'd5);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check("mr_count", count, 16'd0);
    check("mr_done", {15'd0, done}, 16'h0000);
    read_check("mr_load",   9'h181, 16'h0000, 1'b1);
    read_check("mr_status", 9'h183, 16'h0000, 1'b1);

    // Out-of-window write is ignored; LOAD=0 expires at the first tick
    bus_write(9'h101, 16'h0007);
    read_check("oow_load", 9'h181, 16'h0000, 1'b1);
    bus_write(9'h180, 16'h0001);               // edge N
    check("z_n0", count, 16'd0);
    step(3);                                   // N+3
    check("z_n3_done", {15'd0, done}, 16'h0000);
    step(1);                                   // N+4
    check("z_n4_done", {15'd0, done}, 16'h0001);
    read_check("z_status", 9'h183, 16'h0001, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mmio_timer.md
Name: mmio_timer

Overview:
Memory-mapped countdown timer peripheral on the CPU memory bus, alongside RAM, the LED register (0x100) and the switch input (0x140). It decodes mem_cmd/mem_addr from the CPU and responds to a 4-word window at 0x180–0x183. It returns read data to the top-level read_data mux and drives a sticky done flag for an LED or for software polling.

Parameters:
BASE_ADDR, 9'h180, word address of the register window (low 2 bits must be 0)
PRESCALE, 4, clocks per count decrement (>=1)

Ports:
clk  input  1  system clock; all state updates on posedge
reset  input  1  synchronous, active-high reset
mem_cmd  input  3  one-hot bus command: 3'b001 none, 3'b010 read, 3'b100 write
mem_addr  input  9  CPU word address
write_data  input  16  CPU store data
read_data  output  16  register read value; 16'h0000 when rd_en=0
rd_en  output  1  high when mem_cmd=read and the address is in the window (top level uses it as the tri-state enable)
done  output  1  sticky expiry flag
count  output  16  current counter value

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Select: sel = (mem_addr[8:2] == BASE_ADDR[8:2]). Any mem_cmd other than read or write is ignored.
- Register map (offset = mem_addr[1:0]):
  - 0 CTRL: bit0 en, bit1 auto_reload.
  - 1 LOAD: 16-bit reload value.
  - 2 COUNT: current count.
  - 3 STATUS: bit0 done, bit1 running.
  - Unused read bits return 0.
- Reads are combinational: read_data and rd_en are valid in the same cycle as mem_cmd/mem_addr. Reads have no side effects.
- Reset: state IDLE; en=0, auto_reload=0, LOAD=0, count=0, prescaler=0, done=0. With no bus activity, read_data=0 and rd_en=0. Reset mid-run aborts immediately and overrides every other event.
- States:
  - IDLE: counter frozen.
  - RUN: prescaler counting.
  - EXPIRED: count=0, en reads 0.
- Write CTRL with bit0=1 from IDLE or EXPIRED: count<=LOAD, prescaler<=0, state->RUN, auto_reload<=bit1. done is not cleared.
- Write CTRL with bit0=1 while in RUN: only updates auto_reload; count and prescaler are untouched.
- Write CTRL with bit0=0: state->IDLE, count holds, prescaler<=0.
- RUN, each clock:
  - If prescaler==PRESCALE-1: prescaler<=0 and a tick occurs.
  - Otherwise: prescaler<=prescaler+1.
- On a tick:
  - count>1: count<=count-1.
  - count<=1: done<=1. If auto_reload=1 and LOAD!=0, count<=LOAD and stay in RUN. Otherwise count<=0, en<=0, state->EXPIRED.
- Latency: start write at edge N with LOAD=L>=1 sets done at edge N+L*PRESCALE. LOAD=0 expires at the first tick, edge N+PRESCALE.
- Write LOAD: updates the reload register only; the running count is unaffected.
- Write COUNT: count<=write_data, prescaler<=0, in any state; state is unchanged. A bus write to COUNT beats a same-cycle tick.
- Write STATUS with bit0=1: done<=0. A same-cycle expiry set wins, so no event is lost.
- STATUS bit1 (running) = (state==RUN).
- Writes outside the window, or with mem_cmd != write, change nothing.
- Count wraps never: the counter saturates at 0.

Test Plan:
- Reset, then read 0x180–0x183 -> rd_en=1 and read_data=0 each; read 0x100 -> rd_en=0, read_data=0.
- PRESCALE=4: write LOAD=3, write CTRL=1 at edge N -> count 3,2,1,0 at edges N, N+4, N+8, N+12; done=1 at N+12; STATUS reads 16'h0001; CTRL reads 0.
- auto_reload: LOAD=2, CTRL=3 -> done at N+8, count reloads to 2, running stays 1. Write STATUS=1 -> done=0 next edge, then sets again at N+16.
- Clear/set collision: STATUS=1 write in the same cycle as expiry -> done stays 1.
- Write COUNT=16'h0010 mid-run on a tick cycle -> count=16'h0010, prescaler restarts, next decrement 4 clocks later. Write CTRL=0 -> count frozen and running=0.
- Assert reset mid-run with count=5 -> next edge: count=0, done=0, state IDLE; LOAD reads 0.
